// File: rtl/hid_event_pkg.sv
// rtl/hid_event_pkg.sv - shared constants and types for the HID event queue
//
// Register offset select (hid_addr[3]), STATUS/CTRL bit positions, the status
// word layout and the timestamp width. No ports.
package hid_event_pkg;

  // hid_addr[3] selects the register within a channel window
  localparam logic DATA_OFS = 1'b0;
  localparam logic CTRL_OFS = 1'b1;

  // STATUS read bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_MASK      = 8;
  localparam int ST_COUNT_LSB = 48;

  // CTRL write bit positions
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_MASK    = 8;

  localparam int TS_W = 31;

  typedef struct packed {
    logic [15:0] count;
    logic [38:0] rsvd_hi;
    logic        irq_mask;
    logic [4:0]  rsvd_lo;
    logic        overflow;
    logic        full;
    logic        empty;
  } status_t;

endpackage

// File: rtl/hid_event_chan.sv
// rtl/hid_event_chan.sv - one event channel: storage, pointers, count, overflow, irq mask
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   push, push_data       event strobe and payload (payload may carry a timestamp)
//   pop                   advance head (ignored when empty)
//   flush                 empty the queue; a coincident push is discarded
//   clr_ovf               clear the sticky overflow flag
//   mask_we, mask_in      load irq_mask
//   head_data             entry at head (undefined when empty)
//   count, empty, full    occupancy
//   overflow, irq_mask    sticky drop flag, interrupt enable
module hid_event_chan #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int SW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [SW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          mask_we,
  input  logic          mask_in,
  output logic [SW-1:0] head_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          irq_mask
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          mask_q;
  logic          do_pop;
  logic          do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop in the same cycle frees a slot, so a push into a full queue survives.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mask_q  <= 1'b0;
    end else begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) tail_q <= tail_q + PTR_ONE;
        if (do_pop)  head_q <= head_q + PTR_ONE;
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
      // A fresh drop outranks a clear in the same cycle so it is never lost.
      if (push & ~do_push & ~flush) ovf_q <= 1'b1;
      else if (clr_ovf)             ovf_q <= 1'b0;
      if (mask_we) mask_q <= mask_in;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push & ~flush) mem[tail_q] <= push_data;
  end

  assign head_data = mem[head_q];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign irq_mask  = mask_q;

endmodule

// File: rtl/hid_event_fifo.sv
// rtl/hid_event_fifo.sv - multi-channel HID event queue with hid_* register bus
//
// Optional feature macro: HID_EVENT_TIMESTAMP_EN (31-bit cycle timestamp per event).
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   ev_valid_i     per-channel push strobe
//   ev_data_i      channel c payload at [c*DW +: DW]
//   hid_en         bus access strobe
//   hid_we         byte write enables, any set bit means write
//   hid_addr       [7:4] channel, [3] 0=DATA 1=CTRL/STATUS
//   hid_wrdata     write data
//   hid_rddata     registered read data, holds while hid_en is low
//   irq_o          registered OR of (non-empty & irq_mask) over channels
module hid_event_fifo
  import hid_event_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    ev_valid_i,
  input  logic [NCH*DW-1:0] ev_data_i,
  input  logic              hid_en,
  input  logic [7:0]        hid_we,
  input  logic [7:0]        hid_addr,
  input  logic [63:0]       hid_wrdata,
  output logic [63:0]       hid_rddata,
  output logic              irq_o
);

`ifdef HID_EVENT_TIMESTAMP_EN
  localparam int SW = DW + TS_W;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end
`else
  localparam int SW = DW;
`endif

  logic       bus_wr;
  logic [3:0] ch_sel;
  logic       is_ctrl;
  logic       is_data;
  logic [63:0] data_word [NCH];
  logic [63:0] stat_word [NCH];
  logic [NCH-1:0] irq_req;
  logic [63:0] rd_next;
  logic        unused_bits;

  assign bus_wr  = hid_en & (|hid_we);
  assign ch_sel  = hid_addr[7:4];
  assign is_ctrl = (hid_addr[3] == CTRL_OFS);
  assign is_data = (hid_addr[3] == DATA_OFS);
  assign unused_bits = &{1'b0, hid_addr[2:0], hid_wrdata[63:9], hid_wrdata[7:2]};

  function automatic logic [63:0] fmt_data(input logic empty, input logic [SW-1:0] head);
    logic [63:0] w;
    w = '0;
    if (!empty) begin
      w[63]     = 1'b1;
      w[DW-1:0] = head[DW-1:0];
`ifdef HID_EVENT_TIMESTAMP_EN
      w[32 +: TS_W] = head[DW +: TS_W];
`else
      w[32 +: TS_W] = '0;
`endif
    end
    return w;
  endfunction

  function automatic logic [63:0] fmt_status(input logic [AW:0] cnt, input logic mask,
                                              input logic ovf, input logic full, input logic empty);
    status_t s;
    s = '0;
    s[ST_COUNT_LSB +: 16] = 16'(cnt);
    s[ST_MASK]  = mask;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          sel;
    logic [SW-1:0] push_data;
    logic [SW-1:0] head_data;
    logic [AW:0]   count;
    logic          empty, full, overflow, irq_mask;

    assign sel = bus_wr && (ch_sel == 4'(c));
`ifdef HID_EVENT_TIMESTAMP_EN
    assign push_data = {ts_q, ev_data_i[c*DW +: DW]};
`else
    assign push_data = ev_data_i[c*DW +: DW];
`endif

    hid_event_chan #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (ev_valid_i[c]),
      .push_data (push_data),
      .pop       (sel & is_data),
      .flush     (sel & is_ctrl & hid_wrdata[CTRL_FLUSH]),
      .clr_ovf   (sel & is_ctrl & hid_wrdata[CTRL_CLR_OVF]),
      .mask_we   (sel & is_ctrl),
      .mask_in   (hid_wrdata[CTRL_MASK]),
      .head_data (head_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .irq_mask  (irq_mask)
    );

    assign data_word[c] = fmt_data(empty, head_data);
    assign stat_word[c] = fmt_status(count, irq_mask, overflow, full, empty);
    assign irq_req[c]   = ~empty & irq_mask;
  end

  // Channels at or above NCH match no arm and read as zero.
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel == 4'(c)) rd_next = is_ctrl ? stat_word[c] : data_word[c];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hid_rddata <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (hid_en) hid_rddata <= rd_next;
      irq_o <= |irq_req;
    end
  end

endmodule

// File: tb/tb_hid_event_fifo.sv
// tb/tb_hid_event_fifo.sv - randomized self-checking bench for hid_event_fifo
module tb_hid_event_fifo;

  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    ev_valid;
  logic [NCH*DW-1:0] ev_data;
  logic              hid_en;
  logic [7:0]        hid_we;
  logic [7:0]        hid_addr;
  logic [63:0]       hid_wrdata;
  logic [63:0]       hid_rddata;
  logic              irq_o;

  always #5 clk_i = ~clk_i;

  hid_event_fifo #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ev_valid_i (ev_valid),
    .ev_data_i  (ev_data),
    .hid_en     (hid_en),
    .hid_we     (hid_we),
    .hid_addr   (hid_addr),
    .hid_wrdata (hid_wrdata),
    .hid_rddata (hid_rddata),
    .irq_o      (irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel is a queue of {timestamp, payload}.
  logic [62:0] mq [NCH][$];
  logic        m_ovf  [NCH];
  logic        m_mask [NCH];
  logic [30:0] m_ts;
  logic [63:0] exp_rd;
  logic        exp_irq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ovf[c]  = 1'b0;
      m_mask[c] = 1'b0;
    end
    m_ts    = '0;
    exp_rd  = '0;
    exp_irq = 1'b0;
  endtask

  function automatic logic [63:0] model_read(input logic [7:0] a);
    int c;
    int n;
    c = int'(a[7:4]);
    if (c >= NCH) return 64'h0;
    n = mq[c].size();
    if (!a[3]) begin
      if (n == 0) return 64'h0;
      return {1'b1, mq[c][0]};
    end
    return {16'(n), 39'h0, m_mask[c], 5'h0, m_ovf[c], 1'(n == DEPTH), 1'(n == 0)};
  endfunction

  task automatic model_step();
    logic        wr;
    int          ch;
    logic [30:0] ts_now;
    wr = hid_en && (hid_we != 8'h00);
    ch = int'(hid_addr[7:4]);
`ifdef HID_EVENT_TIMESTAMP_EN
    ts_now = m_ts;
`else
    ts_now = '0;
`endif
    for (int c = 0; c < NCH; c++) begin
      logic pop_c, ctrl_c, drop;
      pop_c  = wr && (ch == c) && !hid_addr[3];
      ctrl_c = wr && (ch == c) && hid_addr[3];
      drop   = 1'b0;
      if (ctrl_c && hid_wrdata[0]) begin
        mq[c].delete();
      end else begin
        if (pop_c && mq[c].size() > 0) void'(mq[c].pop_front());
        if (ev_valid[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back({ts_now, ev_data[c*DW +: DW]});
          else drop = 1'b1;
        end
      end
      if (ctrl_c && hid_wrdata[1]) m_ovf[c] = 1'b0;
      if (drop) m_ovf[c] = 1'b1;
      if (ctrl_c) m_mask[c] = hid_wrdata[8];
    end
    m_ts = m_ts + 31'd1;
  endtask

  // One clock: predict from pre-edge model state, advance model, compare after edge.
  task automatic cycle();
    logic [63:0] nx_rd;
    logic        nx_irq;
    nx_rd  = hid_en ? model_read(hid_addr) : exp_rd;
    nx_irq = 1'b0;
    for (int c = 0; c < NCH; c++) if (mq[c].size() > 0 && m_mask[c]) nx_irq = 1'b1;
    @(posedge clk_i);
    model_step();
    exp_rd  = nx_rd;
    exp_irq = nx_irq;
    #1;
    check_eq("rddata", hid_rddata, exp_rd);
    check_eq("irq", {63'h0, irq_o}, {63'h0, exp_irq});
  endtask

  task automatic idle();
    ev_valid   = '0;
    ev_data    = '0;
    hid_en     = 1'b0;
    hid_we     = 8'h00;
    hid_addr   = 8'h00;
    hid_wrdata = '0;
  endtask

  task automatic push_ev(input int ch, input logic [31:0] d);
    idle();
    ev_valid[ch]       = 1'b1;
    ev_data[ch*DW +: DW] = d;
    cycle();
    idle();
  endtask

  task automatic bus(input logic [7:0] we, input logic [7:0] a, input logic [63:0] wd);
    idle();
    hid_en     = 1'b1;
    hid_we     = we;
    hid_addr   = a;
    hid_wrdata = wd;
    cycle();
    idle();
  endtask

  logic [31:0] tp1 [3];
  logic [30:0] ts_a, ts_b, ts_d;

  initial begin
    tp1[0] = 32'h1C; tp1[1] = 32'hF0; tp1[2] = 32'h1C;
    idle();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset_rd", hid_rddata, 64'h0);
    check_eq("reset_irq", {63'h0, irq_o}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Scan-code sequence drained with read+write pops.
    push_ev(0, 32'h1C); push_ev(0, 32'hF0); push_ev(0, 32'h1C);
    for (int i = 0; i < 3; i++) begin
      bus(8'hFF, 8'h00, 64'h0);
      check_eq("tp1_pop", {31'h0, hid_rddata[63], hid_rddata[31:0]}, {31'h0, 1'b1, tp1[i]});
    end
    bus(8'hFF, 8'h00, 64'h0);
    check_eq("tp1_empty", hid_rddata, 64'h0);

    // Overflow on the 17th push, then clear it.
    repeat (17) push_ev(0, $urandom);
    bus(8'h00, 8'h08, 64'h0);
    check_eq("tp2_full", hid_rddata, 64'h0010_0000_0000_0006);
    bus(8'hFF, 8'h08, 64'h2);
    bus(8'h00, 8'h08, 64'h0);
    check_eq("tp2_clr", hid_rddata, 64'h0010_0000_0000_0002);

    // Push and pop together on a full channel.
    idle();
    ev_valid[0] = 1'b1; ev_data[31:0] = 32'hABCD;
    hid_en = 1'b1; hid_we = 8'hFF; hid_addr = 8'h00;
    cycle();
    bus(8'h00, 8'h08, 64'h0);
    check_eq("tp3_count", hid_rddata, 64'h0010_0000_0000_0002);
    repeat (16) bus(8'hFF, 8'h00, 64'h0);
    check_eq("tp3_last", {31'h0, hid_rddata[63], hid_rddata[31:0]}, {31'h0, 1'b1, 32'hABCD});

    // Interrupt rise and fall on channel 1.
    bus(8'hFF, 8'h18, 64'h100);
    push_ev(1, 32'h55);
    check_eq("irq_pre", {63'h0, irq_o}, 64'h0);
    cycle();
    check_eq("irq_rise", {63'h0, irq_o}, 64'h1);
    bus(8'hFF, 8'h10, 64'h0);
    cycle();
    check_eq("irq_fall", {63'h0, irq_o}, 64'h0);

    // Flush racing a push.
    push_ev(0, 32'h1); push_ev(0, 32'h2);
    idle();
    ev_valid[0] = 1'b1; ev_data[31:0] = 32'h3;
    hid_en = 1'b1; hid_we = 8'h01; hid_addr = 8'h08; hid_wrdata = 64'h1;
    cycle();
    bus(8'h00, 8'h08, 64'h0);
    check_eq("tp5_flush", hid_rddata, 64'h1);

    // Out-of-range channel.
    bus(8'hFF, 8'h28, 64'h1FF);
    bus(8'h00, 8'h20, 64'h0);
    check_eq("bad_ch", hid_rddata, 64'h0);

    // Timestamp spacing of two pushes five cycles apart.
    push_ev(0, 32'h7);
    repeat (4) cycle();
    push_ev(0, 32'h8);
    bus(8'hFF, 8'h00, 64'h0); ts_a = hid_rddata[62:32];
    bus(8'hFF, 8'h00, 64'h0); ts_b = hid_rddata[62:32];
    ts_d = ts_b - ts_a;
`ifdef HID_EVENT_TIMESTAMP_EN
    check_eq("ts_delta", {33'h0, ts_d}, 64'd5);
`else
    check_eq("ts_zero", {2'b0, ts_a, ts_b}, 64'h0);
`endif

    // Random traffic alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 2000; i++) begin
      logic drain;
      drain      = ((i / 150) % 2) == 1;
      ev_valid   = drain ? (($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00) : 2'($urandom);
      ev_data    = {$urandom, $urandom};
      hid_en     = ($urandom_range(0, 3) != 0);
      hid_we     = ($urandom_range(0, drain ? 1 : 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      hid_addr   = {4'($urandom_range(0, 2)), 1'($urandom_range(0, drain ? 5 : 1) == 0), 3'($urandom)};
      hid_wrdata = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) hid_wrdata[0] = 1'b0;
      cycle();
    end
    idle();

    // Asynchronous reset between clock edges.
    push_ev(0, 32'h11); push_ev(0, 32'h22);
    bus(8'h00, 8'h08, 64'h0);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("async_rd", hid_rddata, 64'h0);
    check_eq("async_irq", {63'h0, irq_o}, 64'h0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    bus(8'h00, 8'h08, 64'h0);
    check_eq("post_rst", hid_rddata, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hid_event_fifo.md
Name: hid_event_fifo

Overview:
Parametrised, multi-channel event queue for HID peripherals (keyboard scan codes, mouse packets, future touch/gamepad sources), replacing per-device vendor FIFO primitives with portable inferred storage. Each channel accepts single-cycle event strobes from a device decoder and buffers them. Software drains the queues through the hid_* memory-mapped bus, using registered read data and write-to-pop semantics. Per-channel overflow detection, flush and a maskable level interrupt are included.

Parameters:
NCH, 2, number of independent event channels (1..16)
DW, 32, event payload width in bits (1..32)
DEPTH, 16, entries per channel; must be a power of 2, minimum 2
AW, $clog2(DEPTH), derived pointer width; do not override

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
ev_valid_i  in  NCH  per-channel push strobe, one event per cycle
ev_data_i  in  NCH*DW  channel c payload at [c*DW +: DW]
hid_en  in  1  bus access strobe
hid_we  in  8  byte write enables; any bit set means write
hid_addr  in  8  local offset: [7:4] channel, [3]=0 DATA, [3]=1 CTRL/STATUS, [2:0] ignored
hid_wrdata  in  64  write data
hid_rddata  out  64  registered read data
irq_o  out  1  OR over channels of (non-empty & irq_mask)

Behaviour:
- Reset: all pointers and counts = 0; overflow = 0; irq_mask = 0; hid_rddata = 0; irq_o = 0; timestamp counter = 0.
- Push: ev_valid_i[c] and the channel is not full → write to tail, tail+1 (wraps mod DEPTH), count+1.
- Push when full: event dropped and overflow[c] set sticky. Exception: a pop in the same cycle frees space, so the push is accepted and count is unchanged.
- Pop: hid_en & |hid_we on DATA of channel c → head+1, count−1. Pop when empty is ignored; no underflow.
- Push and pop in the same cycle on a non-empty channel: both performed, count unchanged.
- Push and pop in the same cycle on an empty channel: push performed, pop ignored.
- Read latency: hid_rddata is updated on the clock edge after hid_en; it holds its value when hid_en = 0.
- A combined read+write to DATA returns the pre-pop head.
- DATA read format:
  - [63] valid (channel non-empty)
  - [62:32] timestamp (see Optional Feature)
  - [DW-1:0] head payload; remaining bits 0
  - Fields are all 0 when the channel is empty.
- CTRL/STATUS read format:
  - [63:48] count, zero-extended
  - [8] irq_mask
  - [2] overflow
  - [1] full
  - [0] empty
- CTRL/STATUS write:
  - wrdata[0] = 1: flush (head = tail = count = 0)
  - wrdata[1] = 1: clear overflow
  - wrdata[8]: loads irq_mask
- Flush concurrent with a push: flush wins, the push is discarded, overflow is not set.
- Channel index ≥ NCH: reads return 0; writes are ignored.
- irq_o is registered: asserts one cycle after the condition becomes true.
- Reset asserted mid-operation clears all state immediately (asynchronous); queued events are lost.

Optional Feature:
- Macro: HID_EVENT_TIMESTAMP_EN.
- Enabled:
  - A free-running 31-bit cycle counter (wraps) is captured alongside each accepted push.
  - The captured value is returned in DATA[62:32].
  - Per-channel storage is DW+31 bits wide.
- Disabled:
  - No counter is built; DATA[62:32] reads 0.
  - Storage is DW bits wide.

Decomposition:
- Package hid_event_pkg:
  - register offset constants (DATA_OFS, CTRL_OFS)
  - STATUS bit-position constants
  - typedef for the status word
  - TS_W = 31
- Sub-module hid_event_chan: one channel, containing storage, pointers, count, overflow and mask.
  - Instantiated NCH times in a generate loop.
  - Top level does address decode, read mux/register and the irq OR.

Test Plan:
- Push 0x1C, 0xF0, 0x1C on channel 0; read DATA three times, writing after each → reads 0x8000_0000_0000_001C, …00F0, …001C; the fourth read returns 0.
- Push 17 events into a DEPTH=16 channel → STATUS reads count=16, full=1, overflow=1; the 17th event is absent. Write CTRL 0x2 → overflow=0; count is still 16.
- Full channel, push and pop in the same cycle → count stays 16; the new event appears as the last entry after draining.
- Set irq_mask on channel 1, push one event → irq_o rises 1 cycle later; pop → irq_o falls 1 cycle after the pop.
- Flush write coincident with ev_valid_i → count=0, empty=1, overflow=0.
- With HID_EVENT_TIMESTAMP_EN, push on cycle N and on cycle N+5 → DATA[62:32] differs by exactly 5. Without the macro, DATA[62:32] reads 0.
